// File: rtl/oam_dma_arbiter_if.sv
// Byte-wide memory bus between a bus master and its target.
// Used for both the CPU side and the memory side of the DMA arbiter.
interface oam_dma_arbiter_if;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        ddrv;
    logic        read;
    logic        write;
    logic [7:0]  din;

    modport master (
        output adr, dout, ddrv, read, write,
        input  din
    );

    modport slave (
        input  adr, dout, ddrv, read, write,
        output din
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Shares the external bus between the CPU and an OAM DMA engine.
// One byte per M-cycle: read at ph1, write at ph3; CPU locked out while busy.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADR = 16'hFF46,
    parameter logic [15:0] DST_BASE    = 16'hFE00,
    parameter int unsigned LENGTH      = 160
) (
    input  logic              clk,
    input  logic              reset,
    oam_dma_arbiter_if.slave  cpu,
    oam_dma_arbiter_if.master mem,
    output logic              dma_busy
);
    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [8:0] LAST = 9'(LENGTH - 1);

    state_t     st;
    state_t     st_nx;
    logic [1:0] ph;
    logic [7:0] src_hi;
    logic [7:0] idx;
    logic [7:0] idx_nx;
    logic [7:0] buf_q;
    logic       pending;
    logic       pending_nx;
    logic       reg_hit;
    logic       trig;
    logic       go;
    logic       last;

    assign reg_hit  = cpu.adr == DMA_REG_ADR;
    assign trig     = reg_hit && cpu.write;
    // A trigger on the ph3 edge counts as already pending, so restart wins.
    assign go       = (ph == 2'd3) && (pending || trig);
    assign last     = {1'b0, idx} == LAST;
    assign dma_busy = st == XFER;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph      <= 2'd0;
            src_hi  <= 8'h00;
            pending <= 1'b0;
            idx     <= 8'h00;
            buf_q   <= 8'h00;
        end else begin
            ph      <= ph + 2'd1;
            pending <= pending_nx;
            idx     <= idx_nx;
            if (trig) begin
                src_hi <= cpu.dout;
            end
            if (st == XFER && ph == 2'd1) begin
                buf_q <= mem.din;
            end
        end
    end

    always_comb begin
        st_nx      = st;
        idx_nx     = idx;
        pending_nx = pending || trig;
        if (go) begin
            st_nx      = XFER;
            idx_nx     = 8'h00;
            pending_nx = 1'b0;
        end else if (st == XFER && ph == 2'd3) begin
            if (last) begin
                st_nx = IDLE;
            end else begin
                idx_nx = idx + 8'd1;
            end
        end
    end

    always_comb begin
        mem.adr   = cpu.adr;
        mem.dout  = cpu.dout;
        mem.ddrv  = cpu.ddrv;
        mem.read  = cpu.read;
        mem.write = cpu.write;
        cpu.din   = mem.din;
        if (st == XFER) begin
            cpu.din   = reg_hit ? src_hi : 8'hFF;
            mem.dout  = buf_q;
            mem.ddrv  = 1'b0;
            mem.read  = 1'b0;
            mem.write = 1'b0;
            if (ph[1]) begin
                mem.adr   = DST_BASE + {8'h00, idx};
                mem.ddrv  = 1'b1;
                mem.write = ph[0];
            end else begin
                mem.adr  = {src_hi, idx};
                mem.read = ph[0];
            end
        end else if (reg_hit) begin
            cpu.din   = src_hi;
            mem.ddrv  = 1'b0;
            mem.read  = 1'b0;
            mem.write = 1'b0;
        end
    end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: M-cycle level reference model, per-cycle
// compare, directed scenarios plus randomized CPU traffic and restarts.
module tb_oam_dma_arbiter;
    localparam logic [15:0] REG = 16'hFF46;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic busy1;
    always #5 clk = ~clk;

    oam_dma_arbiter_if cpu_bus ();
    oam_dma_arbiter_if mem_bus ();
    oam_dma_arbiter_if c1_bus ();
    oam_dma_arbiter_if m1_bus ();

    oam_dma_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu(cpu_bus), .mem(mem_bus), .dma_busy(busy)
    );

    oam_dma_arbiter #(.LENGTH(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu(c1_bus), .mem(m1_bus), .dma_busy(busy1)
    );

    function automatic logic [7:0] pat(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mdin(logic [15:0] a);
        return (a == 16'h1234) ? 8'h5A : pat(a);
    endfunction

    assign mem_bus.din = mdin(mem_bus.adr);
    assign m1_bus.din  = pat(m1_bus.adr);

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // OAM capture: everything the bus writes into FExx
    logic [7:0] oam [256];
    bit         oam_wr [256];
    int         oam_n = 0;
    bit         oam_clr = 1'b0;
    always @(posedge clk) begin
        if (oam_clr) begin
            for (int i = 0; i < 256; i++) oam_wr[i] <= 1'b0;
            oam_n <= 0;
        end else if (mem_bus.write && mem_bus.adr[15:8] == 8'hFE) begin
            oam[mem_bus.adr[7:0]]    <= mem_bus.dout;
            oam_wr[mem_bus.adr[7:0]] <= 1'b1;
            oam_n <= oam_n + 1;
        end
    end

    int          n1 = 0;
    logic [15:0] a1 = '0;
    logic [7:0]  d1 = '0;
    always @(posedge clk) begin
        if (m1_bus.write) begin
            n1 <= n1 + 1;
            a1 <= m1_bus.adr;
            d1 <= m1_bus.dout;
        end
    end

    // Reference model: phase within M-cycle, byte number, source page
    int         ph_m = 0;
    bit         m_busy = 1'b0;
    bit         m_pend = 1'b0;
    bit         mt;
    logic [7:0] m_src = '0;
    logic [7:0] m_idx = '0;
    logic [7:0] m_buf = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_m = 0; m_busy = 0; m_pend = 0;
            m_src = '0; m_idx = '0; m_buf = '0;
        end else begin
            mt = cpu_bus.write && cpu_bus.adr == REG;
            if (m_busy && ph_m == 1) m_buf = mdin({m_src, m_idx});
            if (ph_m == 3 && (m_pend || mt)) begin
                m_busy = 1; m_idx = '0; m_pend = 0;
            end else begin
                if (mt) m_pend = 1;
                if (m_busy && ph_m == 3) begin
                    if (m_idx == 8'd159) m_busy = 0;
                    else m_idx = m_idx + 8'd1;
                end
            end
            if (mt) m_src = cpu_bus.dout;
            ph_m = (ph_m + 1) % 4;
        end
    end

    logic [35:0] act_v;
    logic [35:0] exp_v;
    logic [15:0] xa;
    logic [7:0]  xi;
    logic [7:0]  xo;
    logic        xr, xw, xd, dc;

    always @(negedge clk) begin
        xa = cpu_bus.adr; xo = cpu_bus.dout;
        xr = cpu_bus.read; xw = cpu_bus.write;
        xd = cpu_bus.ddrv; xi = mdin(cpu_bus.adr);
        if (m_busy) begin
            xi = (cpu_bus.adr == REG) ? m_src : 8'hFF;
            xr = 0; xw = 0; xd = 0; xo = m_buf;
            if (ph_m < 2) begin
                xa = {m_src, m_idx};
                xr = (ph_m == 1);
            end else begin
                xa = 16'hFE00 + {8'h00, m_idx};
                xd = 1;
                xw = (ph_m == 3);
            end
        end else if (cpu_bus.adr == REG) begin
            xr = 0; xw = 0; xd = 0; xi = m_src;
        end
        dc = m_busy && !xd;
        act_v = {busy, mem_bus.read, mem_bus.write, mem_bus.ddrv,
                 mem_bus.adr, cpu_bus.din, dc ? 8'h00 : mem_bus.dout};
        exp_v = {m_busy, xr, xw, xd, xa, xi, dc ? 8'h00 : xo};
        check("cycle", act_v, exp_v);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_bus.adr = '0; cpu_bus.dout = '0; cpu_bus.ddrv = 0;
        cpu_bus.read = 0; cpu_bus.write = 0;
    endtask

    task automatic wait_ph(int p);
        for (int k = 0; k < 8 && ph_m != p; k++) tick();
    endtask

    task automatic dma_wr(logic [7:0] v);
        cpu_bus.adr = REG; cpu_bus.dout = v;
        cpu_bus.ddrv = 1; cpu_bus.write = 1; cpu_bus.read = 0;
        tick();
        cpu_idle();
    endtask

    task automatic clr_oam();
        oam_clr = 1;
        tick();
        oam_clr = 0;
    endtask

    task automatic rand_cpu();
        logic [15:0] a;
        int op;
        a = 16'($urandom);
        if (a == REG) a = 16'hC000;
        op = $urandom_range(0, 2);
        cpu_bus.adr = a;
        cpu_bus.dout = 8'($urandom);
        cpu_bus.read = (op == 1);
        cpu_bus.write = (op == 2);
        cpu_bus.ddrv = (op == 2);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1);
    end

    int cnt;
    int bad;
    logic [7:0] src;

    initial begin
        cpu_idle();
        c1_bus.adr = '0; c1_bus.dout = '0; c1_bus.ddrv = 0;
        c1_bus.read = 0; c1_bus.write = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_bus.read, mem_bus.write, mem_bus.ddrv}, 0);
        check("rst_dout", mem_bus.dout, 0);
        tick();
        reset = 0;

        // idle passthrough
        cpu_bus.adr = 16'h1234; cpu_bus.read = 1;
        #1;
        check("idle_rd_adr", mem_bus.adr, 16'h1234);
        check("idle_rd_strobe", mem_bus.read, 1);
        check("idle_rd_din", cpu_bus.din, 8'h5A);
        tick();
        cpu_idle();
        cpu_bus.adr = 16'hC000; cpu_bus.dout = 8'h77;
        cpu_bus.ddrv = 1; cpu_bus.write = 1;
        #1;
        check("idle_wr_strobe", mem_bus.write, 1);
        check("idle_wr_dout", mem_bus.dout, 8'h77);
        tick();
        cpu_idle();

        // basic transfer with lockout probes
        clr_oam();
        wait_ph(1);
        cpu_bus.adr = REG; cpu_bus.dout = 8'hC1;
        cpu_bus.ddrv = 1; cpu_bus.write = 1;
        #1;
        check("reg_wr_blocked", {mem_bus.write, mem_bus.ddrv}, 0);
        tick();
        cpu_idle();
        check("busy_lat0", busy, 0);
        tick();
        check("busy_lat1", busy, 0);
        tick();
        check("busy_start", busy, 1);
        cnt = 0;
        for (int k = 0; k < 1000 && busy; k++) begin
            cnt++;
            if (cnt == 40) begin
                cpu_bus.adr = 16'hC000; cpu_bus.read = 1;
                #1;
                check("lock_rd", cpu_bus.din, 8'hFF);
            end else if (cnt == 80) begin
                cpu_bus.adr = 16'hD000; cpu_bus.dout = 8'h99;
                cpu_bus.ddrv = 1; cpu_bus.write = 1;
                #1;
                check("lock_wr", mem_bus.adr[15:8] == 8'hD0, 0);
            end else if (cnt == 120) begin
                cpu_bus.adr = REG; cpu_bus.read = 1;
                #1;
                check("lock_reg", cpu_bus.din, 8'hC1);
            end else begin
                cpu_idle();
            end
            tick();
        end
        cpu_idle();
        check("busy_len", cnt, 640);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (!oam_wr[i] || oam[i] != pat(16'hC100 + 16'(i))) bad++;
        check("copy_c1", bad, 0);
        check("copy_n", oam_n, 160);
        check("copy_last", oam[159], pat(16'hC19F));

        // restart at byte 50
        clr_oam();
        dma_wr(8'hC1);
        for (int k = 0; k < 2000 && !(m_busy && m_idx == 50 && ph_m == 0); k++)
            tick();
        dma_wr(8'hD0);
        wait_ph(0);
        check("restart_adr", mem_bus.adr, 16'hD000);
        cnt = 0;
        for (int k = 0; k < 1000 && busy; k++) begin
            cnt++;
            tick();
        end
        check("restart_len", cnt, 640);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (oam[i] != pat(16'hD000 + 16'(i))) bad++;
        check("copy_d0", bad, 0);
        check("restart_n", oam_n, 211);

        // randomized traffic, phases and restarts
        for (int r = 0; r < 3; r++) begin
            src = 8'($urandom_range(0, 255));
            if (src == 8'hFE) src = 8'h80;
            wait_ph($urandom_range(0, 3));
            dma_wr(src);
            for (int k = 0; k < 700; k++) begin
                rand_cpu();
                if ($urandom_range(0, 299) == 0) begin
                    cpu_bus.adr = REG; cpu_bus.write = 1; cpu_bus.ddrv = 1;
                end
                tick();
            end
            cpu_idle();
            for (int k = 0; k < 2000 && busy; k++) tick();
            check("rand_done", busy, 0);
        end

        // reset in the middle of a transfer
        clr_oam();
        dma_wr(8'hC1);
        for (int k = 0; k < 2000 && !(m_busy && m_idx == 10 && ph_m == 2); k++)
            tick();
        reset = 1;
        #1;
        check("rst_mid", {busy, mem_bus.write, mem_bus.ddrv}, 0);
        tick();
        tick();
        reset = 0;
        tick();
        check("fe0a_unwritten", oam_wr[10], 0);
        check("fe09_written", oam_wr[9], 1);
        cpu_bus.adr = 16'h1234; cpu_bus.read = 1;
        #1;
        check("post_rst_din", cpu_bus.din, 8'h5A);
        tick();
        cpu_idle();

        // LENGTH=1 instance
        c1_bus.adr = REG; c1_bus.dout = 8'h42;
        c1_bus.ddrv = 1; c1_bus.write = 1;
        tick();
        c1_bus.adr = '0; c1_bus.dout = '0;
        c1_bus.ddrv = 0; c1_bus.write = 0;
        for (int k = 0; k < 8 && !busy1; k++) tick();
        cnt = 0;
        for (int k = 0; k < 20 && busy1; k++) begin
            cnt++;
            tick();
        end
        tick();
        check("len1_busy", cnt, 4);
        check("len1_nwr", n1, 1);
        check("len1_adr", a1, 16'hFE00);
        check("len1_dat", d1, pat(16'h4200));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the single external memory bus and shares it between the lr35902-style CPU core and an OAM DMA engine.
- A CPU write to the DMA register starts a block copy of LENGTH bytes from {src_hi, 8'h00} to DST_BASE, at one byte per machine cycle (4 clocks).
- While the copy runs, the CPU is locked off the bus.
- Sits between the CPU bus pins and the memory/peripheral decoder.

Parameters:
- DMA_REG_ADR, 16'hFF46, CPU address of the DMA source register.
- DST_BASE, 16'hFE00, destination base address (OAM).
- LENGTH, 160, bytes per transfer; range 1..256.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- reset  in  1  asynchronous, active-high.
- cpu_adr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_ddrv  in  1  CPU drives data.
- cpu_read  in  1  CPU read strobe.
- cpu_write  in  1  CPU write strobe.
- cpu_din  out  8  read data returned to the CPU.
- mem_adr  out  16  bus address.
- mem_dout  out  8  bus write data.
- mem_ddrv  out  1  bus data drive enable.
- mem_read  out  1  bus read strobe.
- mem_write  out  1  bus write strobe.
- mem_din  in  8  bus read data; asynchronous, valid in the same clock as mem_read.
- dma_busy  out  1  transfer in progress.

Behaviour:
- Phase counter `ph[1:0]`:
  - Free-running, +1 every clk, wraps 3->0.
  - Reset to 0, so it stays aligned with the CPU cycle counter, which resets in the same edge.
- Registers:
  - `src_hi[7:0]`, reset 0x00.
  - `pending`, reset 0.
  - `busy`, reset 0.
  - `idx[7:0]`, reset 0.
  - `buf[7:0]`, reset 0x00.
- dma_busy = busy, so it is 0 out of reset.
- Idle (busy=0), mem port is a combinational passthrough:
  - mem_* = cpu_*, cpu_din = mem_din.
  - Exception: when cpu_adr == DMA_REG_ADR, mem_read=0, mem_write=0, mem_ddrv=0, and cpu_din = src_hi.
- Reset output values:
  - Passthrough follows the CPU, whose strobes are 0 in reset.
  - So mem_read = mem_write = mem_ddrv = 0, and mem_dout = 0.
- Trigger:
  - Any rising edge with cpu_write=1 and cpu_adr=DMA_REG_ADR loads src_hi <= cpu_dout and sets pending <= 1.
  - The write is never forwarded to memory.
- Start:
  - At the edge where ph==3 and pending=1: busy <= 1, idx <= 0, pending <= 0.
  - The transfer therefore occupies the M-cycle following the trigger M-cycle.
- Per M-cycle while busy (combinational mem outputs from ph/idx):
  - ph0: mem_adr = {src_hi, idx}, all strobes 0.
  - ph1: mem_adr = {src_hi, idx}, mem_read=1; at the end-of-ph1 edge, buf <= mem_din.
  - ph2: mem_adr = DST_BASE + idx, mem_dout = buf, mem_ddrv=1, strobes 0.
  - ph3: same address/data, mem_ddrv=1, mem_write=1; at the end-of-ph3 edge, idx <= idx+1.
  - If idx == LENGTH-1 at that edge, busy <= 0 instead (unless pending: see restart).
- Length: exactly LENGTH M-cycles (4*LENGTH clocks) with busy=1. Address arithmetic is 16-bit and wraps mod 2^16.
- CPU during busy:
  - Reads of DMA_REG_ADR return src_hi.
  - All other CPU reads return 8'hFF.
  - All other CPU writes are dropped (never reach the mem port).
  - CPU strobes have no effect on the mem_* signals.
- Restart:
  - A DMA_REG_ADR write while busy reloads src_hi and sets pending.
  - The in-flight byte uses the old src_hi only if its ph1 read edge has already passed.
  - At the next ph3 edge the transfer restarts: idx <= 0, busy stays 1.
- Simultaneous events: when the trigger write and the final ph3 edge coincide, restart wins and busy does not drop.
- Reset mid-transfer:
  - All registers return to their reset values immediately, asynchronously.
  - Partially copied OAM is left as-is; no further writes occur.

Test Plan:
- Reset then idle: CPU read 0x1234 with mem_din=0x5A -> mem_adr=0x1234, mem_read=1, cpu_din=0x5A. CPU write 0xC000=0x77 -> mem_write=1, mem_dout=0x77.
- Trigger: write 0xC1 to 0xFF46 -> mem_write stays 0. busy=1 from the next ph0, for 640 clocks. Memory model receives writes FE00..FE9F = contents of C100..C19F, one per M-cycle, at ph3.
- Lockout: during busy, CPU read 0xC000 -> cpu_din=0xFF, no extra mem_read. CPU write 0xD000 -> no mem write. Read 0xFF46 -> 0xC1.
- Restart: at idx=50, write 0xD0 to 0xFF46 -> next transfer byte reads D000 and writes FE00. Total busy after the restart = 160 M-cycles.
- Reset mid-transfer: assert reset at idx=10, ph2 -> busy, mem_write, mem_ddrv = 0 within the same cycle. After release, passthrough resumes and FE0A is unwritten.
- LENGTH=1 parameter build: trigger -> exactly one 4-clock busy window, one write to DST_BASE.
